// File: rtl/reverse_bits_stream.sv
// reverse_bits_stream: per-word bit/byte/nibble transform feeding a 2-entry
// in-order buffer with valid/ready handshakes on both sides.
// Optional transfer counter enabled by defining REVERSE_BITS_STATS_EN;
// otherwise xfer_cnt is tied to zero.
module reverse_bits_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      xfer_cnt
);

  localparam int unsigned NBYTES = WIDTH / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;   // oldest word, always on out_data
  logic [WIDTH-1:0] tail_q, tail_d;   // second word, valid only in FULL
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] xf_data;
  logic             in_xfer, out_xfer;

  // Mode travels with its own word: the transform is applied on entry.
  function automatic logic [WIDTH-1:0] transform(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'b01: begin
        for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      end
      2'b10: begin
        for (int unsigned b = 0; b < NBYTES; b++)
          r[8*b +: 8] = d[8*(NBYTES-1-b) +: 8];
      end
      2'b11: begin
        for (int unsigned b = 0; b < NBYTES; b++)
          r[8*b +: 8] = {d[8*b +: 4], d[8*b+4 +: 4]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign xf_data   = transform(in_data, in_mode);
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Buffer occupancy and storage next-state; in_ready is precomputed from
  // the next state so it leaves a register with no path from out_ready.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = xf_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = xf_data;
        end else if (in_xfer) begin
          tail_d  = xf_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // State and storage registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef REVERSE_BITS_STATS_EN
  logic [15:0] cnt_q;

  // Count completed output transfers, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_reverse_bits_stream.sv
// Scoreboard bench for reverse_bits_stream: one 8-bit and one 16-bit instance.
// Stimulus pushes hand-computed expected words on acceptance; monitors pop
// and compare on each output transfer.
module tb_reverse_bits_stream;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic        rst8_n, i8_valid, i8_ready, o8_valid, o8_ready;
  logic [7:0]  i8_data, o8_data;
  logic [1:0]  i8_mode;
  logic [15:0] x8;

  // 16-bit instance signals
  logic        rst16_n, i16_valid, i16_ready, o16_valid, o16_ready;
  logic [15:0] i16_data, o16_data;
  logic [1:0]  i16_mode;
  logic [15:0] x16;

  reverse_bits_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_data(i8_data), .in_mode(i8_mode),
    .in_valid(i8_valid), .in_ready(i8_ready), .out_data(o8_data),
    .out_valid(o8_valid), .out_ready(o8_ready), .xfer_cnt(x8)
  );

  reverse_bits_stream #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_data(i16_data), .in_mode(i16_mode),
    .in_valid(i16_valid), .in_ready(i16_ready), .out_data(o16_data),
    .out_valid(o16_valid), .out_ready(o16_ready), .xfer_cnt(x16)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned npop8    = 0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [15:0] mcnt8  = '0;
  logic [15:0] mcnt16 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] model);
`ifdef REVERSE_BITS_STATS_EN
    return model;
`else
    return 16'h0000 & model;
`endif
  endfunction

  // 8-bit output monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst8_n) begin
      q8.delete();
      mcnt8 = '0;
    end else if (o8_valid && o8_ready) begin
      if (q8.size() == 0) begin
        check("m8_unexpected_output", {56'd0, o8_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("m8_data", {56'd0, o8_data}, {56'd0, q8.pop_front()});
      end
      check("m8_xfer_cnt", {48'd0, x8}, {48'd0, cnt_exp(mcnt8)});
      mcnt8 = mcnt8 + 16'd1;
      npop8++;
    end
  end

  // 16-bit output monitor.
  always @(negedge clk) begin
    if (!rst16_n) begin
      q16.delete();
      mcnt16 = '0;
    end else if (o16_valid && o16_ready) begin
      if (q16.size() == 0) begin
        check("m16_unexpected_output", {48'd0, o16_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("m16_data", {48'd0, o16_data}, {48'd0, q16.pop_front()});
      end
      check("m16_xfer_cnt", {48'd0, x16}, {48'd0, cnt_exp(mcnt16)});
      mcnt16 = mcnt16 + 16'd1;
    end
  end

  // One cycle on the 8-bit instance: drive, decide acceptance at negedge,
  // return 1 ns after the next rising edge.
  task automatic step8(input logic r, input logic v, input logic [7:0] d,
                       input logic [1:0] m, input logic [7:0] e,
                       input logic ordy, output logic acc);
    rst8_n = r; i8_valid = v; i8_data = d; i8_mode = m; o8_ready = ordy;
    @(negedge clk);
    acc = r && v && i8_ready;
    if (acc) q8.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input logic r, input logic v, input logic [15:0] d,
                        input logic [1:0] m, input logic [15:0] e,
                        input logic ordy, output logic acc);
    rst16_n = r; i16_valid = v; i16_data = d; i16_mode = m; o16_ready = ordy;
    @(negedge clk);
    acc = r && v && i16_ready;
    if (acc) q16.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic       acc;
  logic [7:0] d8;
  int unsigned pop_base;

  initial begin
    rst8_n = 1'b0; i8_valid = 1'b0; i8_data = '0; i8_mode = '0; o8_ready = 1'b0;
    rst16_n = 1'b0; i16_valid = 1'b0; i16_data = '0; i16_mode = '0; o16_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step8(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, acc);
    step8(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, acc);
    check("rst_out_valid", {63'd0, o8_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, i8_ready}, 64'd1);
    check("rst_out_data",  {56'd0, o8_data},  64'd0);
    check("rst_xfer_cnt",  {48'd0, x8},       64'd0);

    // Full bit reversal, 1-cycle latency, first word right after reset release
    step8(1'b1, 1'b1, 8'b1011_0001, 2'b01, 8'b1000_1101, 1'b1, acc);
    check("rev_accept",    {63'd0, acc},      64'd1);
    check("rev_out_valid", {63'd0, o8_valid}, 64'd1);
    check("rev_out_data",  {56'd0, o8_data},  64'h8D);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    check("rev_xfer_cnt",  {48'd0, x8}, {48'd0, cnt_exp(16'd1)});

    // Nibble swap and byte reversal on an 8-bit word
    step8(1'b1, 1'b1, 8'hA5, 2'b11, 8'h5A, 1'b1, acc);
    check("nib8_out_data", {56'd0, o8_data}, 64'h5A);
    step8(1'b1, 1'b1, 8'h3C, 2'b10, 8'h3C, 1'b1, acc);
    check("byte8_out_data", {56'd0, o8_data}, 64'h3C);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);

    // Backpressure: fill to FULL, hold, then drain in order
    step8(1'b1, 1'b1, 8'h01, 2'b00, 8'h01, 1'b0, acc);
    step8(1'b1, 1'b1, 8'h02, 2'b00, 8'h02, 1'b0, acc);
    check("full_in_ready",  {63'd0, i8_ready}, 64'd0);
    check("full_out_valid", {63'd0, o8_valid}, 64'd1);
    check("full_out_data",  {56'd0, o8_data},  64'h01);
    step8(1'b1, 1'b1, 8'h33, 2'b00, 8'h33, 1'b0, acc);
    check("full_ignore_in", {63'd0, acc},     64'd0);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, acc);
    check("full_hold_data", {56'd0, o8_data}, 64'h01);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    check("drain_in_ready", {63'd0, i8_ready}, 64'd1);
    check("drain_out_data", {56'd0, o8_data},  64'h02);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    check("drain_empty",    {63'd0, o8_valid}, 64'd0);

    // Back-to-back 10 words from a fresh reset
    step8(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    pop_base = npop8;
    for (int i = 0; i < 10; i++) begin
      d8 = 8'(i * 29 + 7);
      step8(1'b1, 1'b1, d8, 2'b00, d8, 1'b1, acc);
      check("b2b_accept",    {63'd0, acc},      64'd1);
      check("b2b_out_valid", {63'd0, o8_valid}, 64'd1);
      check("b2b_out_data",  {56'd0, o8_data},  {56'd0, d8});
    end
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    check("b2b_pops",     64'(npop8 - pop_base), 64'd10);
    check("b2b_xfer_cnt", {48'd0, x8}, {48'd0, cnt_exp(16'd10)});
    check("b2b_empty",    {63'd0, o8_valid}, 64'd0);

    // Reset while FULL discards words; next word has 1-cycle latency
    step8(1'b1, 1'b1, 8'hAA, 2'b00, 8'hAA, 1'b0, acc);
    step8(1'b1, 1'b1, 8'hBB, 2'b00, 8'hBB, 1'b0, acc);
    check("pre_rst_full", {63'd0, i8_ready}, 64'd0);
    step8(1'b0, 1'b1, 8'hCC, 2'b00, 8'hCC, 1'b1, acc);
    check("frst_out_valid", {63'd0, o8_valid}, 64'd0);
    check("frst_in_ready",  {63'd0, i8_ready}, 64'd1);
    check("frst_xfer_cnt",  {48'd0, x8},       64'd0);
    check("frst_out_data",  {56'd0, o8_data},  64'd0);
    step8(1'b1, 1'b1, 8'hC3, 2'b11, 8'h3C, 1'b1, acc);
    check("frst_next_valid", {63'd0, o8_valid}, 64'd1);
    check("frst_next_data",  {56'd0, o8_data},  64'h3C);
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);

    // Counter wrap: 65537 transfers
    step8(1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    for (int i = 0; i < 65537; i++) begin
      d8 = 8'(i);
      step8(1'b1, 1'b1, d8, 2'b00, d8, 1'b1, acc);
    end
    step8(1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, acc);
    check("wrap_xfer_cnt", {48'd0, x8}, {48'd0, cnt_exp(16'd1)});

    // 16-bit transforms
    step16(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b1, acc);
    check("rst16_out_valid", {63'd0, o16_valid}, 64'd0);
    step16(1'b1, 1'b1, 16'h12A4, 2'b10, 16'hA412, 1'b1, acc);
    check("w16_byte_rev", {48'd0, o16_data}, 64'hA412);
    step16(1'b1, 1'b1, 16'h12A4, 2'b11, 16'h214A, 1'b1, acc);
    check("w16_nib_swap", {48'd0, o16_data}, 64'h214A);
    step16(1'b1, 1'b1, 16'h12A4, 2'b00, 16'h12A4, 1'b1, acc);
    check("w16_pass", {48'd0, o16_data}, 64'h12A4);
    step16(1'b1, 1'b1, 16'h12A4, 2'b01, 16'h2548, 1'b1, acc);
    check("w16_bit_rev", {48'd0, o16_data}, 64'h2548);
    step16(1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b1, acc);
    check("w16_xfer_cnt", {48'd0, x16}, {48'd0, cnt_exp(16'd4)});

    check("q8_drained",  64'(q8.size()),  64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
